// File: rtl/pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : pattern_generator
// Description : Parallel-to-serial pattern generator that sends each word
//               MSB-first and supports back-to-back words with no idle cycle.
//               Defining PATTERN_GENERATOR_PARITY_EN appends an even-parity bit
//               to every non-empty word.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_generator #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       enable,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  input  logic [$clog2(WIDTH+1)-1:0] load_len,
  output logic                       load_ready,
  output logic                       serial_pattern,
  output logic                       serial_valid,
  output logic                       serial_last
);

  localparam int                 c_LEN_W   = $clog2(WIDTH + 1);
  localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(WIDTH);
  localparam logic [c_LEN_W-1:0] c_LEN_ONE = c_LEN_W'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
`ifdef PATTERN_GENERATOR_PARITY_EN
  localparam logic [1:0] c_PARITY = 2'd2;
`endif

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [c_LEN_W-1:0] r_cnt;
  logic [c_LEN_W-1:0] w_len;
  logic [c_LEN_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_aligned;
  logic               w_accept;
  logic               w_start;
  logic               w_final;
  logic               w_shift_ready;
`ifdef PATTERN_GENERATOR_PARITY_EN
  logic               r_parity;
`endif

  // Left-align the word so the first bit to send always sits in the MSB.
  assign w_len     = (load_len > c_LEN_MAX) ? c_LEN_MAX : load_len;
  assign w_shamt   = c_LEN_MAX - w_len;
  assign w_aligned = load_data << w_shamt;
  assign w_accept  = load_ready & load_valid;
  assign w_start   = w_accept & (w_len != '0);
  assign w_final   = (r_state == c_SHIFT) && (r_cnt == '0);

`ifdef PATTERN_GENERATOR_PARITY_EN
  assign w_shift_ready = 1'b0;
`else
  assign w_shift_ready = (r_cnt == '0);
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start) w_state_nxt = c_SHIFT;
        end
        c_SHIFT: begin
          if (r_cnt == '0) begin
`ifdef PATTERN_GENERATOR_PARITY_EN
            w_state_nxt = c_PARITY;
`else
            w_state_nxt = w_start ? c_SHIFT : c_IDLE;
`endif
          end
        end
`ifdef PATTERN_GENERATOR_PARITY_EN
        c_PARITY: w_state_nxt = w_start ? c_SHIFT : c_IDLE;
`endif
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // Gating with rstb keeps load_ready low while reset is held.
  always_comb begin
    load_ready = 1'b0;
    if (rstb && enable) begin
      case (r_state)
        c_IDLE:   load_ready = 1'b1;
        c_SHIFT:  load_ready = w_shift_ready;
`ifdef PATTERN_GENERATOR_PARITY_EN
        c_PARITY: load_ready = 1'b1;
`endif
        default:  load_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_shift        <= '0;
      r_cnt          <= '0;
      serial_pattern <= 1'b0;
      serial_valid   <= 1'b0;
      serial_last    <= 1'b0;
`ifdef PATTERN_GENERATOR_PARITY_EN
      r_parity       <= 1'b0;
`endif
    end else if (!enable) begin
      r_shift        <= '0;
      r_cnt          <= '0;
      serial_pattern <= 1'b0;
      serial_valid   <= 1'b0;
      serial_last    <= 1'b0;
    end else if (w_start) begin
      r_shift        <= w_aligned << 1;
      r_cnt          <= w_len - c_LEN_ONE;
      serial_pattern <= w_aligned[WIDTH-1];
      serial_valid   <= 1'b1;
`ifdef PATTERN_GENERATOR_PARITY_EN
      serial_last    <= 1'b0;
      r_parity       <= w_aligned[WIDTH-1];
`else
      serial_last    <= (w_len == c_LEN_ONE);
`endif
    end else if ((r_state == c_SHIFT) && (r_cnt != '0)) begin
      r_shift        <= r_shift << 1;
      r_cnt          <= r_cnt - c_LEN_ONE;
      serial_pattern <= r_shift[WIDTH-1];
      serial_valid   <= 1'b1;
`ifdef PATTERN_GENERATOR_PARITY_EN
      serial_last    <= 1'b0;
      r_parity       <= r_parity ^ r_shift[WIDTH-1];
`else
      serial_last    <= (r_cnt == c_LEN_ONE);
`endif
    end
`ifdef PATTERN_GENERATOR_PARITY_EN
    else if (w_final) begin
      // r_parity already folds in bit 0, so it is the even-parity bit.
      serial_pattern <= r_parity;
      serial_valid   <= 1'b1;
      serial_last    <= 1'b1;
    end
`endif
    else begin
      r_shift        <= '0;
      r_cnt          <= '0;
      serial_pattern <= 1'b0;
      serial_valid   <= 1'b0;
      serial_last    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_generator
// Description : Scoreboard bench for pattern_generator; a queue of expected
//               serial bits is filled on acceptance and drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_generator;

  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);
`ifdef PATTERN_GENERATOR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             enable = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic [LW-1:0]    load_len = '0;
  logic             load_ready;
  logic             serial_pattern;
  logic             serial_valid;
  logic             serial_last;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0]       exp_q[$];   // {bit, last}
  logic [1:0]       mon_e;
  logic             mon_on = 1'b0;
  logic             last_acc = 1'b0;
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;
  int               hold_l = 0;

  always #5 clk = ~clk;

  pattern_generator #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .enable        (enable),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_len      (load_len),
    .load_ready    (load_ready),
    .serial_pattern(serial_pattern),
    .serial_valid  (serial_valid),
    .serial_last   (serial_last)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Monitor: every cycle the outputs either present the next queued bit or are all zero.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("serial_valid", serial_valid, 1'b1);
        check("serial_pattern", serial_pattern, mon_e[1]);
        check("serial_last", serial_last, mon_e[0]);
      end else begin
        check("idle_valid", serial_valid, 1'b0);
        check("idle_pattern", serial_pattern, 1'b0);
        check("idle_last", serial_last, 1'b0);
      end
    end
  end

  // Drive one cycle of inputs; the block is ready exactly when no bit is still
  // queued behind the one currently on the output.
  task automatic step(input logic en, input logic v, input logic [WIDTH-1:0] d, input int len);
    int   L;
    logic par;
    logic exp_ready;
    @(negedge clk);
    #2;
    enable     = en;
    load_valid = v;
    load_data  = d;
    load_len   = LW'(len);
    #1;
    exp_ready = rstb && en && (exp_q.size() == 0);
    check("load_ready", load_ready, exp_ready);
    last_acc = exp_ready && v;
    if (!en) begin
      exp_q.delete();
    end else if (last_acc) begin
      L   = (len > WIDTH) ? WIDTH : len;
      par = 1'b0;
      for (int i = L - 1; i >= 0; i--) begin
        par ^= d[i];
        exp_q.push_back({d[i], (i == 0) && !PAR});
      end
      if (PAR && L > 0) exp_q.push_back({par, 1'b1});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    load_valid = 1'b0;
    rstb = 1'b0;
    #1;
    check("rst_ready", load_ready, 1'b0);
    check("rst_valid", serial_valid, 1'b0);
    check("rst_pattern", serial_pattern, 1'b0);
    check("rst_last", serial_last, 1'b0);
    exp_q.delete();
    @(negedge clk);
    #3;
    rstb = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 0);
  endtask

  initial begin
    enable = 1'b1;
    #3;
    check("por_ready", load_ready, 1'b0);
    check("por_valid", serial_valid, 1'b0);
    check("por_pattern", serial_pattern, 1'b0);
    check("por_last", serial_last, 1'b0);
    @(negedge clk);
    #3;
    rstb   = 1'b1;
    mon_on = 1'b1;

    // Full-length word
    step(1'b1, 1'b1, 8'hB2, 8);
    idle(10);

    // Back-to-back words; the second is held until accepted
    step(1'b1, 1'b1, 8'h05, 3);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'h02, 2);
      if (last_acc) break;
    end
    check("b2b_accepted", last_acc, 1'b1);
    idle(5);

    // Enable dropped mid-word, then a single-bit word
    step(1'b1, 1'b1, 8'hB2, 8);
    idle(3);
    step(1'b0, 1'b0, '0, 0);
    idle(2);
    step(1'b1, 1'b1, 8'h01, 1);
    idle(4);

    // Asynchronous reset mid-word, then zero-length words
    step(1'b1, 1'b1, 8'hB2, 8);
    idle(2);
    do_reset();
    step(1'b1, 1'b1, 8'h00, 0);
    step(1'b1, 1'b1, 8'hFF, 0);
    idle(3);

    // Parity-specific pattern (also a plain 3-bit word without parity)
    step(1'b1, 1'b1, 8'h07, 3);
    idle(6);

    // Randomized traffic, holding unaccepted words
    for (int k = 0; k < 1500; k++) begin
      if (!(hold_v && !last_acc)) begin
        hold_v = ($urandom_range(0, 9) < 7);
        hold_d = WIDTH'($urandom);
        hold_l = $urandom_range(0, WIDTH + 3);
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        hold_v = 1'b0;
      end
      step(($urandom_range(0, 19) != 0), hold_v, hold_d, hold_l);
    end
    idle(WIDTH + 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
